wb_simcard_buffer: RTL
======================

Name: wb_simcard_buffer

Overview:
- Wishbone classic slave that sits directly downstream of the SIM card reader core.
- Drives the core's Habilitar enable and captures each byte qualified by the core's Dato_Valido into a 64-byte record buffer.
- Tracks the Hecho completion flag.
- Exposes control, status and the buffered bytes to the CPU over Wishbone.

Parameters:
- DEPTH, 64, buffer depth in bytes (power of two).
- AW, 7, Wishbone word-address width; bit AW-1 selects the data window.
- SYNC_STAGES, 2, synchronizer flops on Dato_Valido and Hecho.

Ports:
- CLK_FPGA  input  1  system clock; Wishbone and all logic in this domain.
- RST  input  1  asynchronous, active-low reset.
- wb_cyc_i  input  1  Wishbone cycle.
- wb_stb_i  input  1  Wishbone strobe.
- wb_we_i  input  1  Wishbone write enable.
- wb_adr_i  input  AW  Wishbone word address.
- wb_dat_i  input  8  Wishbone write data.
- wb_dat_o  output  8  Wishbone read data.
- wb_ack_o  output  1  Wishbone acknowledge.
- sim_dato_valido  input  1  byte strobe from the reader core; asynchronous to this block, lasts multiple clocks.
- sim_salida  input  8  byte from the reader core; stable while sim_dato_valido is high.
- sim_hecho  input  1  reader core session-complete level.
- sim_habilitar  output  1  enable to the reader core.
- irq  output  1  level interrupt, high while done and ie are both set.

Behaviour:
- Reset (RST=0): all outputs are 0. wr_ptr=0, count=0, done=0, ovf=0, ie=0, run=0. Buffer contents are don't-care.
- Synchronizers: sim_dato_valido and sim_hecho each pass through SYNC_STAGES flops, then a rising-edge detect (one extra flop).
- Byte capture: cap_pulse is a one-clock pulse on a synchronized rising edge of sim_dato_valido. It is honoured only when run=1.
  - sim_salida is sampled on the same clock as cap_pulse. This is safe because the source holds sim_salida for at least one etu.
  - On cap_pulse with count<DEPTH: mem[wr_ptr] <= sim_salida; wr_ptr <= wr_ptr+1 (wraps mod DEPTH); count <= count+1.
  - On cap_pulse with count==DEPTH: no write, ovf <= 1, count saturates at DEPTH.
- Done: a synchronized rising edge of sim_hecho while run=1 sets done=1 and clears run. Captures stop after that.
- sim_habilitar = run.
- Register map (word address):
  - 0x00 CTRL. Write: bit0 START, bit1 CLEAR, bit2 ie. Read: {5'b0, ie, 1'b0, run}.
    - START=1 with run=0: run <= 1.
    - START=1 with run=1: ignored.
    - CLEAR=1: wr_ptr, count, done, ovf <= 0 and run <= 0. The reader core is reset through Habilitar.
    - CLEAR and START written together: CLEAR takes effect first, then run <= 1 on the same clock.
  - 0x01 STATUS, read-only: {ovf, done, count[6:0]} truncated to 8 bits as {done, ovf, count[5:0]}. count==64 reads as 0 with ovf=0 only after exactly 64 bytes, so software uses the COUNT register instead.
  - 0x02 COUNT, read-only: {1'b0, count[6:0]}.
  - 0x40..0x7F DATA, read-only: mem[wb_adr_i[5:0]]. Writes are ignored but still acked.
  - Unmapped addresses read 0x00 and are acked.
- Wishbone timing:
  - wb_ack_o asserts one clock after wb_cyc_i & wb_stb_i & ~wb_ack_o, for exactly one clock. Every access has 1 wait state.
  - wb_dat_o is registered and valid with ack. It is 0 when ack is low.
- Simultaneous capture and CLEAR: CLEAR wins and the byte is discarded.
- Simultaneous capture and done edge: the byte is stored first, then run clears.
- Asynchronous reset mid-transfer: ack is dropped immediately and the reader core is disabled.

Decomposition:
- Shared package wb_simcard_pkg: register addresses (ADDR_CTRL, ADDR_STATUS, ADDR_COUNT, DATA_BASE) and CTRL bit indices.
- One sub-module, simcard_sync_edge (SYNC_STAGES-flop synchronizer plus rising-edge pulse), instantiated twice.
- Buffer is an inferred register array inside this block.

Test Plan:
- Reset, then read 0x00/0x01/0x02 -> all return 0x00; sim_habilitar=0; irq=0.
- Write CTRL=0x05, then drive 3 Dato_Valido pulses (each 5952 clocks long) with bytes 0x3B, 0x9F, 0x11 -> COUNT=3; reads of 0x40..0x42 return 0x3B, 0x9F, 0x11; sim_habilitar=1.
- After the previous scenario, raise sim_hecho -> done=1, run=0, irq=1, sim_habilitar=0; a further Dato_Valido pulse leaves COUNT=3.
- START, then 65 pulses with bytes 0x00..0x40 -> COUNT=64, ovf=1, mem[63]=0x3F, 0x40 not stored.
- Write CLEAR on the same clock as a cap_pulse -> COUNT=0, byte discarded, sim_habilitar=0.
- Wishbone protocol: back-to-back strobes to 0x7F -> ack pulses are exactly one clock wide with one idle clock between them; a write to 0x45 is acked and the data window is unchanged.

Source files
------------

// File: rtl/wb_simcard_pkg.sv
// Register map and CTRL bit positions for the SIM card record buffer.
package wb_simcard_pkg;

    localparam int ADDR_CTRL   = 'h00;
    localparam int ADDR_STATUS = 'h01;
    localparam int ADDR_COUNT  = 'h02;
    localparam int DATA_BASE   = 'h40;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_IE    = 2;

    typedef enum logic [1:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_COUNT,
        SEL_NONE
    } reg_sel_e;

endpackage

// File: rtl/simcard_sync_edge.sv
// Multi-flop synchronizer for a slow asynchronous level, followed by a one-clock
// rising-edge pulse.
module simcard_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic pulse_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign pulse_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/wb_simcard_buffer.sv
// Wishbone classic slave that enables the SIM card reader core, buffers the bytes
// it produces and reports session completion.
module wb_simcard_buffer
    import wb_simcard_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int AW          = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK_FPGA,
    input  logic          RST,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [7:0]    wb_dat_i,
    output logic [7:0]    wb_dat_o,
    output logic          wb_ack_o,
    input  logic          sim_dato_valido,
    input  logic [7:0]    sim_salida,
    input  logic          sim_hecho,
    output logic          sim_habilitar,
    output logic          irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          cap_pulse;
    logic          hecho_pulse;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          done_q,   done_d;
    logic          ovf_q,    ovf_d;
    logic          ie_q,     ie_d;
    logic          run_q,    run_d;
    logic          ack_q;
    logic [7:0]    dat_q;
    logic [7:0]    mem_q [DEPTH];

    logic          req;
    logic          wr_ctrl;
    logic          do_clear;
    logic          do_start;
    logic          cap_ok;
    logic          full;
    logic          mem_we;
    reg_sel_e      reg_sel;
    logic [7:0]    count8;
    logic [7:0]    rd_data;
    logic          unused_wdat;

    simcard_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_valido (
        .clk     (CLK_FPGA),
        .rst_n   (RST),
        .async_i (sim_dato_valido),
        .pulse_o (cap_pulse)
    );

    simcard_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hecho (
        .clk     (CLK_FPGA),
        .rst_n   (RST),
        .async_i (sim_hecho),
        .pulse_o (hecho_pulse)
    );

    always_comb begin
        reg_sel = SEL_NONE;
        if (!wb_adr_i[AW-1]) begin
            if (wb_adr_i[AW-2:0] == (AW-1)'(ADDR_CTRL))   reg_sel = SEL_CTRL;
            if (wb_adr_i[AW-2:0] == (AW-1)'(ADDR_STATUS)) reg_sel = SEL_STATUS;
            if (wb_adr_i[AW-2:0] == (AW-1)'(ADDR_COUNT))  reg_sel = SEL_COUNT;
        end
    end

    assign req         = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_ctrl     = req & wb_we_i & (reg_sel == SEL_CTRL);
    assign do_clear    = wr_ctrl & wb_dat_i[CTRL_CLEAR];
    assign do_start    = wr_ctrl & wb_dat_i[CTRL_START];
    assign unused_wdat = ^wb_dat_i[7:3];

    // A CLEAR on the same clock as a capture discards the byte.
    assign cap_ok = cap_pulse & run_q & ~do_clear;
    assign full   = (count_q == CW'(DEPTH));
    assign mem_we = cap_ok & ~full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        ie_d     = ie_q;
        run_d    = run_q;

        if (cap_ok) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end

        // The byte captured on a done edge is kept; only run is dropped.
        if (hecho_pulse && run_q) begin
            done_d = 1'b1;
            run_d  = 1'b0;
        end

        if (wr_ctrl) begin
            ie_d = wb_dat_i[CTRL_IE];
            if (do_clear) begin
                wr_ptr_d = '0;
                count_d  = '0;
                done_d   = 1'b0;
                ovf_d    = 1'b0;
                run_d    = 1'b0;
            end
            if (do_start && (!run_q || do_clear)) begin
                run_d = 1'b1;
            end
        end
    end

    assign count8 = 8'(count_q);

    always_comb begin
        rd_data = 8'h00;
        if (wb_adr_i[AW-1]) begin
            rd_data = mem_q[wb_adr_i[PW-1:0]];
        end else begin
            case (reg_sel)
                SEL_CTRL:   rd_data = {5'b0, ie_q, 1'b0, run_q};
                SEL_STATUS: rd_data = {done_q, ovf_q, count8[5:0]};
                SEL_COUNT:  rd_data = count8;
                default:    rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK_FPGA or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ie_q     <= 1'b0;
            run_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            ie_q     <= ie_d;
            run_q    <= run_d;
            ack_q    <= req;
            dat_q    <= req ? rd_data : 8'h00;
        end
    end

    always_ff @(posedge CLK_FPGA) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= sim_salida;
        end
    end

    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign sim_habilitar = run_q;
    assign irq           = done_q & ie_q;

endmodule
